// File: rtl/dram_arbiter_if.sv
// Core-array / shared-RAM bundle for dram_arbiter; the arbiter connects through the slave modport.
interface dram_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
);
    logic [NUM_CORES-1:0]        i_req_rd;
    logic [NUM_CORES-1:0]        i_req_wr;
    logic [ADDR_W*NUM_CORES-1:0] i_addr;
    logic [DATA_W*NUM_CORES-1:0] i_wdata;
    logic [NUM_CORES-1:0]        o_ack;
    logic [DATA_W-1:0]           o_rdata;
    logic [ADDR_W-1:0]           o_dram_addr;
    logic                        o_dram_read;
    logic                        o_dram_write;
    logic [DATA_W-1:0]           o_dram_out;
    logic [DATA_W-1:0]           i_dram_in;
    logic                        o_busy;
    logic [7:0]                  o_grant_id;
    logic [16*NUM_CORES-1:0]     o_stat_grants;

    modport slave (
        input  i_req_rd, i_req_wr, i_addr, i_wdata, i_dram_in,
        output o_ack, o_rdata, o_dram_addr, o_dram_read, o_dram_write,
        output o_dram_out, o_busy, o_grant_id, o_stat_grants
    );

    modport master (
        output i_req_rd, i_req_wr, i_addr, i_wdata, i_dram_in,
        input  o_ack, o_rdata, o_dram_addr, o_dram_read, o_dram_write,
        input  o_dram_out, o_busy, o_grant_id, o_stat_grants
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter serialising per-core DRAM reads/writes onto one memory port.
// Optional per-core grant counters are enabled with the DRAM_ARB_STATS_EN macro.
module dram_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    dram_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_r, state_nx_s;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nx_s;
    logic [IDX_W-1:0]     id_r, id_nx_s;
    logic [3:0]           cnt_r, cnt_nx_s;
    logic [ADDR_W-1:0]    addr_r, addr_nx_s;
    logic [DATA_W-1:0]    wdata_r, wdata_nx_s;
    logic                 op_wr_r, op_wr_nx_s;
    logic [DATA_W-1:0]    rdata_r, rdata_nx_s;
    logic [NUM_CORES-1:0] ack_r, ack_nx_s;
    logic                 rd_r, rd_nx_s;
    logic                 wr_r, wr_nx_s;
    logic                 busy_r;
    logic [7:0]           grant_r, grant_nx_s;
    logic [NUM_CORES-1:0] req_s;
    logic                 found_s;
    logic [IDX_W-1:0]     pick_s;
    logic [IDX_W:0]       sum_s;
    logic [IDX_W:0]       idx_s;

    assign req_s = bus.i_req_rd | bus.i_req_wr;

    // Round-robin scan starting at rr_ptr; the first requester found wins.
    always_comb begin
        found_s = 1'b0;
        pick_s  = rr_ptr_r;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum_s   = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
            idx_s   = (sum_s >= (IDX_W+1)'(NUM_CORES)) ? sum_s - (IDX_W+1)'(NUM_CORES) : sum_s;
            pick_s  = (!found_s && req_s[idx_s[IDX_W-1:0]]) ? idx_s[IDX_W-1:0] : pick_s;
            found_s = found_s | req_s[idx_s[IDX_W-1:0]];
        end
    end

    // FSM next state plus next values of every registered output.
    always_comb begin
        state_nx_s  = state_r;
        rr_ptr_nx_s = rr_ptr_r;
        id_nx_s     = id_r;
        cnt_nx_s    = cnt_r;
        addr_nx_s   = addr_r;
        wdata_nx_s  = wdata_r;
        op_wr_nx_s  = op_wr_r;
        rdata_nx_s  = rdata_r;
        grant_nx_s  = grant_r;
        ack_nx_s    = '0;
        rd_nx_s     = 1'b0;
        wr_nx_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nx_s = ISSUE;
                    id_nx_s    = pick_s;
                    addr_nx_s  = bus.i_addr[pick_s*ADDR_W +: ADDR_W];
                    wdata_nx_s = bus.i_wdata[pick_s*DATA_W +: DATA_W];
                    op_wr_nx_s = bus.i_req_wr[pick_s];
                    grant_nx_s = 8'(pick_s);
                    wr_nx_s    = bus.i_req_wr[pick_s];
                    rd_nx_s    = ~bus.i_req_wr[pick_s];
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_nx_s   = 4'(MEM_LATENCY - 1);
                state_nx_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    if (!op_wr_r) begin
                        rdata_nx_s = bus.i_dram_in;
                    end else begin
                        rdata_nx_s = rdata_r;
                    end
                    ack_nx_s   = {{(NUM_CORES-1){1'b0}}, 1'b1} << id_r;
                    state_nx_s = RESP;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (id_r == IDX_W'(NUM_CORES - 1)) begin
                    rr_ptr_nx_s = '0;
                end else begin
                    rr_ptr_nx_s = id_r + IDX_W'(1);
                end
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            id_r     <= '0;
            cnt_r    <= 4'd0;
            addr_r   <= '0;
            wdata_r  <= '0;
            op_wr_r  <= 1'b0;
            rdata_r  <= '0;
            ack_r    <= '0;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            busy_r   <= 1'b0;
            grant_r  <= 8'd0;
        end else begin
            state_r  <= state_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
            id_r     <= id_nx_s;
            cnt_r    <= cnt_nx_s;
            addr_r   <= addr_nx_s;
            wdata_r  <= wdata_nx_s;
            op_wr_r  <= op_wr_nx_s;
            rdata_r  <= rdata_nx_s;
            ack_r    <= ack_nx_s;
            rd_r     <= rd_nx_s;
            wr_r     <= wr_nx_s;
            busy_r   <= (state_nx_s != IDLE);
            grant_r  <= grant_nx_s;
        end
    end

    assign bus.o_ack        = ack_r;
    assign bus.o_rdata      = rdata_r;
    assign bus.o_dram_addr  = addr_r;
    assign bus.o_dram_read  = rd_r;
    assign bus.o_dram_write = wr_r;
    assign bus.o_dram_out   = wdata_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_grant_id   = grant_r;

`ifdef DRAM_ARB_STATS_EN
    logic [15:0] stat_r [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_stat
        // Saturating count of IDLE->ISSUE grants to core k.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                stat_r[k] <= 16'd0;
            end else if (state_r == IDLE && found_s && pick_s == IDX_W'(k) && stat_r[k] != 16'hFFFF) begin
                stat_r[k] <= stat_r[k] + 16'd1;
            end else begin
                stat_r[k] <= stat_r[k];
            end
        end
        assign bus.o_stat_grants[k*16 +: 16] = stat_r[k];
    end
`else
    assign bus.o_stat_grants = '0;
`endif
endmodule
